// File: rtl/psdsqrt_sched_pkg.sv
// psdsqrt_sched_pkg: shared states, defaults and clog2 for the psdsqrt scheduler
package psdsqrt_sched_pkg;
    localparam int NBITS_DEF = 16;
    localparam int NREQ_DEF  = 4;
    typedef enum logic [2:0] {IDLE, START, RUN, STOP, CAPT, RESP} state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/psdsqrt_rr_arb.sv
// psdsqrt_rr_arb: combinational round-robin grant starting at ptr
module psdsqrt_rr_arb
    import psdsqrt_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);
    logic [IDW-1:0] idx;
    // scan downward so the requester closest above ptr is written last and wins
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        idx    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end
endmodule

// File: rtl/psdsqrt_sched.sv
// psdsqrt_sched: round-robin sharing of one psdsqrt unit; optional ops_done via PSDSQRT_SCHED_PERF_EN
module psdsqrt_sched
    import psdsqrt_sched_pkg::*;
#(
    parameter int NBITS = NBITS_DEF,
    parameter int NREQ  = NREQ_DEF,
    parameter int IDW   = clog2(NREQ)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*NBITS-1:0] req_x,
    output logic [NREQ-1:0]       req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [NBITS/2-1:0]    resp_sqrt,
    output logic [IDW-1:0]        resp_id,
    output logic                  busy,
    output logic                  sq_start,
    output logic                  sq_stop,
    output logic [NBITS-1:0]      sq_xin,
`ifdef PSDSQRT_SCHED_PERF_EN
    output logic [15:0]           ops_done,
`endif
    input  logic [NBITS/2-1:0]    sq_sqrt
);
    localparam int HALF = NBITS / 2;
    localparam int CW   = clog2(HALF) + 1;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic [IDW-1:0] ptr, id, gnt_id;
    logic [NREQ-1:0] gnt;
    logic           take;

    psdsqrt_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_ready = (state == IDLE) ? gnt : '0;
    assign busy      = state != IDLE;

    // next-state logic; take marks the accept edge
    always_comb begin
        state_nx = state;
        take     = 1'b0;
        case (state)
            IDLE:    if (|req_valid) begin
                         take     = 1'b1;
                         state_nx = START;
                     end
            START:   state_nx = RUN;
            RUN:     state_nx = (cnt == CW'(1)) ? STOP : RUN;
            STOP:    state_nx = CAPT;
            CAPT:    state_nx = RESP;
            RESP:    state_nx = resp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // datapath, counter and registered psdsqrt/response strobes
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt        <= '0;
            ptr        <= '0;
            id         <= '0;
            sq_xin     <= '0;
            sq_start   <= 1'b0;
            sq_stop    <= 1'b0;
            resp_valid <= 1'b0;
            resp_sqrt  <= '0;
            resp_id    <= '0;
`ifdef PSDSQRT_SCHED_PERF_EN
            ops_done   <= '0;
`endif
        end else begin
            sq_start   <= state_nx == START;
            sq_stop    <= state_nx == STOP;
            resp_valid <= state_nx == RESP;
            cnt        <= (state == START) ? CW'(HALF) : (state == RUN) ? cnt - CW'(1) : cnt;
            if (take) begin
                sq_xin <= req_x[int'(gnt_id)*NBITS +: NBITS];
                id     <= gnt_id;
                ptr    <= IDW'((int'(gnt_id) + 1) % NREQ);
            end
            if (state == CAPT) begin
                resp_sqrt <= sq_sqrt;
                resp_id   <= id;
            end
`ifdef PSDSQRT_SCHED_PERF_EN
            if (resp_valid && resp_ready) ops_done <= ops_done + 16'd1;
`endif
        end
    end
endmodule
